// File: rtl/cpu_8bit_pkg.sv
// Shared types for the 8-bit A/B datapath micro-sequencer: instruction word layout,
// instruction classes and sequencer states.
package cpu_8bit_pkg;

    localparam int unsigned CLS_W   = 3;
    localparam int unsigned CLS_LSB = 13;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [CLS_W-1:0] {
        ClsNop   = 3'd0,
        ClsLda   = 3'd1,
        ClsLdb   = 3'd2,
        ClsAluA  = 3'd3,
        ClsAluB  = 3'd4,
        ClsMovAB = 3'd5,
        ClsMovBA = 3'd6,
        ClsIll   = 3'd7
    } instr_cls_e;

    typedef struct packed {
        instr_cls_e  cls;
        logic        use_carry;
        logic [3:0]  alu_op;
        logic [7:0]  imm;
    } instr_t;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWrite,
        StDone
    } state_e;

    function automatic logic is_alu_cls(instr_cls_e cls);
        return (cls == ClsAluA) || (cls == ClsAluB);
    endfunction

endpackage

// File: rtl/cpu_8bit_bus_sel.sv
// Combinational decode of instruction class and sequencer state into the bus source,
// destination capture strobe and ALU flag update.
module cpu_8bit_bus_sel
    import cpu_8bit_pkg::*;
(
    input  instr_cls_e cls_i,
    input  state_e     state_i,
    output logic       src_imm_o,
    output logic       src_alu_o,
    output logic       src_a_o,
    output logic       src_b_o,
    output logic       dst_a_o,
    output logic       dst_b_o,
    output logic       flag_sel_o
);

    logic drive;
    logic write;

    // Source holds the bus through setup and the write edge; destination only on the write.
    assign drive = (state_i == StSetup) || (state_i == StWrite);
    assign write = (state_i == StWrite);

    always_comb begin
        src_imm_o  = 1'b0;
        src_alu_o  = 1'b0;
        src_a_o    = 1'b0;
        src_b_o    = 1'b0;
        dst_a_o    = 1'b0;
        dst_b_o    = 1'b0;
        flag_sel_o = 1'b0;
        unique case (cls_i)
            ClsLda: begin
                src_imm_o = drive;
                dst_a_o   = write;
            end
            ClsLdb: begin
                src_imm_o = drive;
                dst_b_o   = write;
            end
            ClsAluA: begin
                src_alu_o  = drive;
                dst_a_o    = write;
                flag_sel_o = write;
            end
            ClsAluB: begin
                src_alu_o  = drive;
                dst_b_o    = write;
                flag_sel_o = write;
            end
            ClsMovAB: begin
                src_a_o = drive;
                dst_b_o = write;
            end
            ClsMovBA: begin
                src_b_o = drive;
                dst_a_o = write;
            end
            ClsNop, ClsIll: begin
            end
        endcase
    end

endmodule

// File: rtl/cpu_8bit_seq_ctrl.sv
// Micro-sequencer: accepts one instruction per handshake and walks it through
// bus setup, a single write edge and a turnaround/retire cycle.
module cpu_8bit_seq_ctrl
    import cpu_8bit_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OP_W      = 4,
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned SETUP_CYC = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_instr_valid,
    output logic               o_instr_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_co,
    output logic               o_a_wrtn,
    output logic               o_a_rdn,
    output logic               o_b_wrtn,
    output logic               o_b_rdn,
    output logic [OP_W-1:0]    o_alu_opcode,
    output logic               o_cin,
    output logic               o_alu_sel,
    output logic               o_alu_flag_sel,
    output logic               o_imm_oe,
    output logic [DATA_W-1:0]  o_imm_data,
    output logic               o_done,
    output logic               o_err
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(SETUP_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    instr_t           instr_q, instr_d;

    logic src_imm, src_alu, src_a, src_b;
    logic dst_a, dst_b, flag_sel;
    logic drive;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        instr_d       = instr_q;
        o_instr_ready = 1'b0;
        o_done        = 1'b0;
        o_err         = 1'b0;
        unique case (state_q)
            StIdle: begin
                o_instr_ready = 1'b1;
                if (i_instr_valid) begin
                    instr_d = instr_t'(i_instr);
                    cnt_d   = CntLoad;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrite: begin
                state_d = StDone;
            end
            StDone: begin
                o_done  = 1'b1;
                o_err   = (instr_q.cls == ClsIll);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    cpu_8bit_bus_sel u_bus_sel (
        .cls_i      (instr_q.cls),
        .state_i    (state_q),
        .src_imm_o  (src_imm),
        .src_alu_o  (src_alu),
        .src_a_o    (src_a),
        .src_b_o    (src_b),
        .dst_a_o    (dst_a),
        .dst_b_o    (dst_b),
        .flag_sel_o (flag_sel)
    );

    assign drive = (state_q == StSetup) || (state_q == StWrite);

    always_comb begin
        o_a_rdn        = ~src_a;
        o_b_rdn        = ~src_b;
        o_a_wrtn       = ~dst_a;
        o_b_wrtn       = ~dst_b;
        o_alu_sel      = src_alu;
        o_imm_oe       = src_imm;
        o_alu_flag_sel = flag_sel & is_alu_cls(instr_q.cls);
        o_alu_opcode   = drive ? OP_W'(instr_q.alu_op) : '0;
        o_cin          = drive & instr_q.use_carry & i_co;
        // Immediate only reaches the bus driver while it actually owns the bus.
        o_imm_data     = src_imm ? DATA_W'(instr_q.imm) : '0;
    end

endmodule

// File: tb/tb_cpu_8bit_seq_ctrl.sv
// Bench for cpu_8bit_seq_ctrl: two instances (1 and 3 setup cycles) checked every cycle
// against a timeline model, plus directed scenarios with literal expectations.
module tb_cpu_8bit_seq_ctrl;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic co  = 1'b0;
    always #5 clk = ~clk;

    logic        vld [2];
    logic [15:0] ins [2];
    logic        rdy [2], a_wrtn [2], a_rdn [2], b_wrtn [2], b_rdn [2];
    logic        cin [2], alu_sel [2], flag_sel [2], imm_oe [2], done [2], err [2];
    logic [3:0]  opc [2];
    logic [7:0]  immd [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_8bit_seq_ctrl #(
            .SETUP_CYC (g == 0 ? S0 : S1)
        ) u_dut (
            .i_clk          (clk),
            .i_rst          (rst),
            .i_instr_valid  (vld[g]),
            .o_instr_ready  (rdy[g]),
            .i_instr        (ins[g]),
            .i_co           (co),
            .o_a_wrtn       (a_wrtn[g]),
            .o_a_rdn        (a_rdn[g]),
            .o_b_wrtn       (b_wrtn[g]),
            .o_b_rdn        (b_rdn[g]),
            .o_alu_opcode   (opc[g]),
            .o_cin          (cin[g]),
            .o_alu_sel      (alu_sel[g]),
            .o_alu_flag_sel (flag_sel[g]),
            .o_imm_oe       (imm_oe[g]),
            .o_imm_data     (immd[g]),
            .o_done         (done[g]),
            .o_err          (err[g])
        );
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit started  = 1'b0;
    bit log_acc1 = 1'b0;
    bit rnd_co   = 1'b0;
    int acc_q [$];
    int age [2];
    int done_cnt [2];
    logic [15:0] cur [2];
    logic [7:0]  dp_a = 8'h00;
    logic [7:0]  dp_b = 8'h00;

    // Output bundle: {ready, a_wrtn, a_rdn, b_wrtn, b_rdn, opcode, cin, alu_sel, flag_sel,
    // imm_oe, imm_data, done, err}
    function automatic logic [22:0] pack_act(int d);
        return {rdy[d], a_wrtn[d], a_rdn[d], b_wrtn[d], b_rdn[d], opc[d], cin[d], alu_sel[d],
                flag_sel[d], imm_oe[d], immd[d], done[d], err[d]};
    endfunction

    // age counts cycles since acceptance: 1..s setup, s+1 write, s+2 done, 0 idle.
    function automatic logic [22:0] expect_f(int a, int s, logic [15:0] w, logic c);
        logic rd, awn, arn, bwn, brn, ci, als, fls, ioe, dn, er;
        logic [3:0] op;
        logic [7:0] imd;
        int cls;
        bit drv, wr;
        cls = int'(w[15:13]);
        drv = (a >= 1) && (a <= s + 1);
        wr  = (a == s + 1);
        rd = (a == 0);
        {awn, arn, bwn, brn} = 4'b1111;
        {ci, als, fls, ioe, dn, er} = 6'b0;
        op  = 4'h0;
        imd = 8'h00;
        if (drv) begin
            op = w[11:8];
            ci = w[12] & c;
            case (cls)
                1, 2: begin ioe = 1'b1; imd = w[7:0]; end
                3, 4: als = 1'b1;
                5:    arn = 1'b0;
                6:    brn = 1'b0;
                default: ;
            endcase
        end
        if (wr) begin
            if (cls == 1 || cls == 3 || cls == 6) awn = 1'b0;
            if (cls == 2 || cls == 4 || cls == 5) bwn = 1'b0;
            fls = (cls == 3 || cls == 4);
        end
        if (a == s + 2) begin
            dn = 1'b1;
            er = (cls == 7);
        end
        return {rd, awn, arn, bwn, brn, op, ci, als, fls, ioe, imd, dn, er};
    endfunction

    function automatic logic [7:0] alu_f(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic c);
        case (op)
            4'd0:    return a + b + {7'd0, c};
            4'd1:    return a - b - {7'd0, c};
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [22:0] e, a;
        logic [7:0]  bus;
        int srcs;
        int s;
        cyc++;
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                s = (d == 0) ? S0 : S1;
                e = expect_f(age[d], s, cur[d], co);
                a = pack_act(d);
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cycle_compare dut%0d cyc=%0d got=%h want=%h", d, cyc, a, e);
                end
                srcs = int'(imm_oe[d]) + int'(alu_sel[d]) + int'(!a_rdn[d]) + int'(!b_rdn[d]);
                checks++;
                if (srcs > 1 || (!a_rdn[d] && !a_wrtn[d]) || (!b_rdn[d] && !b_wrtn[d])) begin
                    failures++;
                    $display("FAIL bus_exclusive dut%0d cyc=%0d got=%0d_sources want=<=1",
                             d, cyc, srcs);
                end
                if (done[d] === 1'b1) done_cnt[d]++;
            end
            // Datapath stand-in driven by dut0's strobes.
            bus = 8'hxx;
            if (imm_oe[0])      bus = immd[0];
            else if (alu_sel[0]) bus = alu_f(opc[0], dp_a, dp_b, cin[0]);
            else if (!a_rdn[0]) bus = dp_a;
            else if (!b_rdn[0]) bus = dp_b;
            if (!a_wrtn[0]) dp_a = bus;
            if (!b_wrtn[0]) dp_b = bus;
        end
        for (int d = 0; d < 2; d++) begin
            s = (d == 0) ? S0 : S1;
            if (rst) begin
                age[d] = 0;
            end else if (age[d] == 0) begin
                if (vld[d]) begin
                    cur[d] = ins[d];
                    age[d] = 1;
                    if (d == 1 && log_acc1) acc_q.push_back(cyc);
                end
            end else begin
                age[d] = (age[d] == s + 2) ? 0 : age[d] + 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_co) co = 1'($urandom);
    end

    function automatic logic [15:0] mk(int cls, int uc, int op, int imm);
        logic [2:0] c3 = 3'(cls);
        logic       u1 = 1'(uc);
        logic [3:0] o4 = 4'(op);
        logic [7:0] i8 = 8'(imm);
        return {c3, u1, o4, i8};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer w to instance d until accepted; returns 1 ns after the accepting edge.
    task automatic issue(input int d, input logic [15:0] w);
        int  n = 0;
        bit  acc = 1'b0;
        vld[d] = 1'b1;
        ins[d] = w;
        while (!acc && n < 100) begin
            acc = rdy[d];
            step();
            n++;
        end
        vld[d] = 1'b0;
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (rdy[d] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(rdy[d]), 32'd1);
    endtask

    initial begin
        int dc;
        vld[0] = 1'b0; vld[1] = 1'b0;
        ins[0] = '0;   ins[1] = '0;
        step();
        started = 1'b1;
        step();
        @(negedge clk);
        chk("reset_ready", 32'(rdy[0]), 32'd1);
        chk("reset_strobes", 32'({a_wrtn[0], a_rdn[0], b_wrtn[0], b_rdn[0]}), 32'hf);
        chk("reset_drivers", 32'({opc[0], cin[0], alu_sel[0], flag_sel[0], imm_oe[0], immd[0],
                                  done[0], err[0]}), 32'h0);
        step();
        rst = 1'b0;
        step();

        // LDA 0x5A timeline
        issue(0, mk(1, 0, 0, 'h5a));
        @(negedge clk);
        chk("lda_setup_imm", 32'({imm_oe[0], a_wrtn[0], immd[0]}), 32'h35a);
        @(negedge clk);
        chk("lda_write_strobe", 32'({imm_oe[0], a_wrtn[0]}), 32'h2);
        @(negedge clk);
        chk("lda_done", 32'({done[0], imm_oe[0], rdy[0]}), 32'h4);
        @(negedge clk);
        chk("lda_ready_back", 32'(rdy[0]), 32'd1);
        step();
        chk("lda_value", 32'(dp_a), 32'h5a);

        // LDA 5, LDB 3, ADD with carry into A
        co = 1'b1;
        issue(0, mk(1, 0, 0, 5));
        issue(0, mk(2, 0, 0, 3));
        issue(0, mk(3, 1, 0, 0));
        @(negedge clk);
        chk("alu_setup", 32'({alu_sel[0], cin[0], flag_sel[0], a_wrtn[0]}), 32'hd);
        @(negedge clk);
        chk("alu_write", 32'({alu_sel[0], cin[0], flag_sel[0], a_wrtn[0]}), 32'he);
        step();
        wait_idle(0);
        chk("alu_result_a", 32'(dp_a), 32'h09);

        // MOV A->B then MOV B->A
        issue(0, mk(5, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        chk("mov_ab_write", 32'({a_rdn[0], b_wrtn[0], b_rdn[0], a_wrtn[0]}), 32'h3);
        step();
        issue(0, mk(1, 0, 0, 'h11));
        issue(0, mk(6, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        chk("mov_ba_write", 32'({b_rdn[0], a_wrtn[0], a_rdn[0], b_wrtn[0]}), 32'h3);
        step();
        wait_idle(0);
        chk("mov_b_value", 32'(dp_b), 32'h09);
        chk("mov_a_value", 32'(dp_a), 32'h09);

        // Illegal class retires silently with err
        issue(0, mk(7, 1, 3, 'hff));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("ill_no_strobe", 32'({imm_oe[0], alu_sel[0], flag_sel[0], a_rdn[0], a_wrtn[0],
                                      b_rdn[0], b_wrtn[0]}), 32'h0f);
        end
        @(negedge clk);
        chk("ill_done_err", 32'({done[0], err[0]}), 32'h3);
        @(negedge clk);
        chk("ill_pulse_end", 32'({done[0], err[0]}), 32'h0);
        step();

        // Reset during setup of ALU->B
        dc = done_cnt[0];
        issue(0, mk(4, 0, 2, 0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", 32'({rdy[0], b_wrtn[0], alu_sel[0], done[0]}), 32'hc);
        repeat (4) step();
        chk("rst_mid_b_kept", 32'(dp_b), 32'h09);
        chk("rst_mid_no_done", 32'(done_cnt[0]), 32'(dc));

        // Back-to-back offers on the 3-setup-cycle instance
        log_acc1 = 1'b1;
        for (int i = 0; i < 4; i++) issue(1, mk(1 + (i % 6), 1, i, 16 * i + 1));
        log_acc1 = 1'b0;
        chk("b2b_accepts", 32'(acc_q.size()), 32'd4);
        for (int i = 1; i < acc_q.size(); i++) chk("b2b_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd6);
        wait_idle(1);

        // Randomized traffic on both instances, with occasional resets
        rnd_co = 1'b1;
        fork
            for (int i = 0; i < 150; i++) begin
                repeat ($urandom_range(0, 2)) step();
                issue(0, 16'($urandom));
            end
            for (int i = 0; i < 100; i++) begin
                repeat ($urandom_range(0, 3)) step();
                issue(1, 16'($urandom));
            end
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(40, 90)) step();
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
        join
        rnd_co = 1'b0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
